// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding, oversampling constants and vote helper for the UART receive path
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [3:0] SAMPLE_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_MID = 4'd8;
    localparam logic [3:0] SAMPLE_HI  = 4'd9;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_START   = 3'd1,
        RX_DATA    = 3'd2,
        RX_STOP    = 3'd3,
        RX_RECOVER = 3'd4
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - received-byte output bundle from the UART receiver to its consumer
interface uart_receiver_if;

    logic [7:0] out_data;
    logic       rxBusy;
    logic       rxDone;
    logic       rxFrameErr;

    modport master (output out_data, output rxBusy, output rxDone, output rxFrameErr);
    modport slave  (input  out_data, input  rxBusy, input  rxDone, input  rxFrameErr);

endinterface

// File: rtl/uart_rx_tick.sv
// rtl/uart_rx_tick.sv - oversample tick divider, one-cycle tick every DIV clocks, synchronous clear
module uart_rx_tick #(
    parameter int DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART 8N1 receiver: 2-flop sync, 16x oversampling, 3-sample majority vote per bit
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rxEn,
    input  logic            rx,
    uart_receiver_if.master rx_if
);

    localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);

    rx_state_t  state, state_n;
    logic       rx_m, rx_s;
    logic [3:0] s_cnt;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_q, data_n;
    logic       busy_q, busy_n, done_n, ferr_n, done_q, ferr_q;
    logic       smp_lo, smp_mid;
    logic       tick, start_det, decide, vote;

    uart_rx_tick #(.DIV(DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_det || !rxEn),
        .tick  (tick)
    );

    assign decide = tick && (s_cnt == SAMPLE_HI);
    assign vote   = majority3(smp_lo, smp_mid, rx_s);

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_cnt_n = bit_cnt;
        data_n    = data_q;
        busy_n    = busy_q;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
        start_det = 1'b0;
        unique case (state)
            RX_IDLE: if (!rx_s) begin
                start_det = 1'b1;
                bit_cnt_n = 3'd0;
                busy_n    = 1'b1;
                state_n   = RX_START;
            end
            RX_START: if (decide) begin
                if (vote) begin
                    busy_n  = 1'b0;
                    state_n = RX_IDLE;
                end else begin
                    state_n = RX_DATA;
                end
            end
            RX_DATA: if (decide) begin
                shift_n   = {vote, shift[7:1]};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = RX_STOP;
            end
            RX_STOP: if (decide) begin
                if (vote) begin
                    data_n  = shift;
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = RX_IDLE;
                end else begin
                    ferr_n  = 1'b1;
                    state_n = RX_RECOVER;
                end
            end
            // Hold off until the line is released so a break is not taken as a new frame.
            RX_RECOVER: if (rx_s) begin
                busy_n  = 1'b0;
                state_n = RX_IDLE;
            end
            default: begin
                busy_n  = 1'b0;
                state_n = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RX_IDLE;
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            s_cnt   <= 4'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            smp_lo  <= 1'b1;
            smp_mid <= 1'b1;
        end else if (!rxEn) begin
            state   <= RX_IDLE;
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            s_cnt   <= 4'd0;
            bit_cnt <= 3'd0;
            shift   <= 8'h00;
            data_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            smp_lo  <= 1'b1;
            smp_mid <= 1'b1;
        end else begin
            state   <= state_n;
            rx_m    <= rx;
            rx_s    <= rx_m;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            ferr_q  <= ferr_n;
            if (start_det) begin
                s_cnt <= 4'd0;
            end else if (tick) begin
                s_cnt <= s_cnt + 4'd1;
            end
            if (tick && s_cnt == SAMPLE_LO)  smp_lo  <= rx_s;
            if (tick && s_cnt == SAMPLE_MID) smp_mid <= rx_s;
        end
    end

    assign rx_if.out_data   = data_q;
    assign rx_if.rxBusy     = busy_q;
    assign rx_if.rxDone     = done_q;
    assign rx_if.rxFrameErr = ferr_q;

endmodule
